// File: rtl/lcd_timing_ctrl_if.sv
// Signal bundle between the LCD timing controller, its pixel generator and the panel.
// master = timing controller side, slave = generator/panel side.
interface lcd_timing_ctrl_if;
  logic        lcd_en;
  logic [23:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic        lcd_bl;
  logic        busy;

  modport master (
    input  lcd_en, pixel_data,
    output pixel_xpos, pixel_ypos, h_disp, v_disp,
           lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, busy
  );

  modport slave (
    output lcd_en, pixel_data,
    input  pixel_xpos, pixel_ypos, h_disp, v_disp,
           lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, busy
  );
endinterface

// File: rtl/lcd_timing_ctrl.sv
// RGB LCD timing generator: h/v counters, syncs, data-enable, frame-gated start/stop, delayed backlight.
// Optional macro LCD_TEST_BAR_EN keeps the panel scanning in IDLE with a 4-bar test pattern.
module lcd_timing_ctrl #(
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int H_DISP   = 480,
  parameter int H_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter int V_DISP   = 272,
  parameter int V_FRONT  = 2,
  parameter int BL_DELAY = 2
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  lcd_timing_ctrl_if.master lcd
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int FW      = (BL_DELAY < 2) ? 1 : $clog2(BL_DELAY + 1);

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] H_REQ_START = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_REQ_END   = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [FW-1:0] BL_TARGET = FW'(BL_DELAY);

`ifdef LCD_TEST_BAR_EN
  localparam bit SCAN_IN_IDLE = 1'b1;
`else
  localparam bit SCAN_IN_IDLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

  state_t        state_reg;
  logic [10:0]   h_cnt_reg;
  logic [10:0]   v_cnt_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          lcd_bl_reg;
  logic          busy_reg;

  logic          h_wrap;
  logic          frame_wrap;
  logic          start_ok;
  logic [10:0]   h_cnt_next;
  logic [10:0]   v_cnt_next;
  logic [FW-1:0] frame_cnt_next;

  assign h_wrap         = (h_cnt_reg == H_LAST);
  assign frame_wrap     = h_wrap && (v_cnt_reg == V_LAST);
  assign h_cnt_next     = h_wrap ? 11'd0 : h_cnt_reg + 11'd1;
  assign v_cnt_next     = !h_wrap ? v_cnt_reg : (frame_wrap ? 11'd0 : v_cnt_reg + 11'd1);
  // Frame count saturates so the backlight stays on for as long as the panel runs.
  assign frame_cnt_next = (frame_wrap && (frame_cnt_reg != BL_TARGET)) ?
                          frame_cnt_reg + FW'(1) : frame_cnt_reg;

`ifdef LCD_TEST_BAR_EN
  assign start_ok = lcd.lcd_en && frame_wrap;
`else
  assign start_ok = lcd.lcd_en;
`endif

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      h_cnt_reg     <= 11'd0;
      v_cnt_reg     <= 11'd0;
      frame_cnt_reg <= '0;
      lcd_bl_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          frame_cnt_reg <= '0;
          lcd_bl_reg    <= 1'b0;
          h_cnt_reg     <= SCAN_IN_IDLE ? h_cnt_next : 11'd0;
          v_cnt_reg     <= SCAN_IN_IDLE ? v_cnt_next : 11'd0;
          if (start_ok) begin
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
            lcd_bl_reg <= (BL_DELAY == 0);
          end
        end
        RUN, STOP_PEND: begin
          h_cnt_reg <= h_cnt_next;
          v_cnt_reg <= v_cnt_next;
          if ((state_reg == STOP_PEND) && !lcd.lcd_en && frame_wrap) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            lcd_bl_reg    <= 1'b0;
            frame_cnt_reg <= '0;
          end else begin
            state_reg     <= lcd.lcd_en ? RUN : STOP_PEND;
            frame_cnt_reg <= frame_cnt_next;
            lcd_bl_reg    <= (frame_cnt_next == BL_TARGET);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic scan;
  logic line_act;
  logic de;
  logic data_req;

  assign scan     = SCAN_IN_IDLE || (state_reg != IDLE);
  assign line_act = (v_cnt_reg >= V_ACT_START) && (v_cnt_reg < V_ACT_END);
  assign de       = scan && line_act && (h_cnt_reg >= H_ACT_START) && (h_cnt_reg < H_ACT_END);
  // Requests lead the enable by one pixel so the registered generator output lines up with de.
  assign data_req = scan && line_act && (h_cnt_reg >= H_REQ_START) && (h_cnt_reg < H_REQ_END);

  assign lcd.lcd_hs     = !(scan && (h_cnt_reg < H_SYNC_END));
  assign lcd.lcd_vs     = !(scan && (v_cnt_reg < V_SYNC_END));
  assign lcd.lcd_de     = de;
  assign lcd.pixel_xpos = data_req ? h_cnt_reg - H_REQ_START : 11'd0;
  assign lcd.pixel_ypos = data_req ? v_cnt_reg - V_ACT_START : 11'd0;
  assign lcd.h_disp     = 11'(H_DISP);
  assign lcd.v_disp     = 11'(V_DISP);
  assign lcd.lcd_bl     = lcd_bl_reg;
  assign lcd.busy       = busy_reg;

`ifdef LCD_TEST_BAR_EN
  localparam logic [10:0] BAR1 = 11'(H_DISP / 4);
  localparam logic [10:0] BAR2 = 11'(2 * (H_DISP / 4));
  localparam logic [10:0] BAR3 = 11'(3 * (H_DISP / 4));
  logic [10:0] col;
  logic [23:0] bar_rgb;

  assign col = h_cnt_reg - H_ACT_START;
  always_comb begin
    bar_rgb = 24'h0000ff;
    if (col < BAR1)      bar_rgb = 24'hffffff;
    else if (col < BAR2) bar_rgb = 24'hff0000;
    else if (col < BAR3) bar_rgb = 24'h00ff00;
  end
  assign lcd.lcd_rgb = !de ? 24'd0 : ((state_reg == IDLE) ? bar_rgb : lcd.pixel_data);
`else
  assign lcd.lcd_rgb = de ? lcd.pixel_data : 24'd0;
`endif
endmodule
